// File: rtl/bcd_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner_pkg
//   Shared definitions for the two-digit seven-segment scanner:
//   - FSM state encodings (plain localparams so older tools can use them)
//   - Active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   - A small elaboration-time helper for sizing the slot counter
// -----------------------------------------------------------------------------
package bcd_display_scanner_pkg;

  // Scan FSM. Each digit slot begins with a dead (blanked) interval.
  localparam int          STATE_W     = 2;
  localparam logic [1:0]  ST_DEAD_T   = 2'd0;
  localparam logic [1:0]  ST_TENS     = 2'd1;
  localparam logic [1:0]  ST_DEAD_O   = 2'd2;
  localparam logic [1:0]  ST_ONES     = 2'd3;

  // Segment patterns, active-high, {g,f,e,d,c,b,a}.
  localparam logic [6:0]  SEG_0       = 7'b0111111;
  localparam logic [6:0]  SEG_1       = 7'b0000110;
  localparam logic [6:0]  SEG_2       = 7'b1011011;
  localparam logic [6:0]  SEG_3       = 7'b1001111;
  localparam logic [6:0]  SEG_4       = 7'b1100110;
  localparam logic [6:0]  SEG_5       = 7'b1101101;
  localparam logic [6:0]  SEG_6       = 7'b1111101;
  localparam logic [6:0]  SEG_7       = 7'b0000111;
  localparam logic [6:0]  SEG_8       = 7'b1111111;
  localparam logic [6:0]  SEG_9       = 7'b1101111;
  localparam logic [6:0]  SEG_DASH    = 7'b1000000;
  localparam logic [6:0]  SEG_OFF     = 7'b0000000;

  // Larger of two integers; used to size a counter shared by two intervals.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : bcd_display_scanner_pkg

// File: rtl/bcd_display_scanner_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//   Purely combinational BCD to seven-segment decoder, active-high output.
//   Codes 10..15 are not BCD and show a dash so a bad upstream value is
//   visible on the display rather than silently rendered as a stray glyph.
//
// Ports
//   digit  in  4  BCD digit
//   seg    out 7  active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seven_seg_decoder
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule : seven_seg_decoder

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//   Drives a two-digit common-anode seven-segment display by time
//   multiplexing. Incoming BCD digits are captured into a shadow register on
//   load and only committed to the display registers at the frame boundary,
//   so a digit never changes partway through a scan. Every digit slot starts
//   with a blanked dead interval to suppress ghosting between digits.
//
//   Scan order: DEAD_T -> TENS -> DEAD_O -> ONES -> DEAD_T ...
//   With DEAD_CYCLES == 0 the dead states are skipped (TENS <-> ONES).
//
// Parameters
//   REFRESH_DIV     clocks each digit is lit per slot (>= 2)
//   DEAD_CYCLES     blanked clocks at the start of each slot (0 = none)
//   SEG_ACTIVE_LOW  1: seg bit 0 lights the segment
//   AN_ACTIVE_LOW   1: an bit 0 enables the digit
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   load        in   1  one-cycle strobe, capture n2/n1
//   n2          in   4  tens digit (BCD)
//   n1          in   4  ones digit (BCD)
//   blank_lz    in   1  darken the tens digit while it is zero (sampled live)
//   seg         out  7  segments {g,f,e,d,c,b,a}, registered
//   an          out  2  digit enables {tens,ones}, registered
//   frame_tick  out  1  one-cycle pulse after the edge that ends a frame
// -----------------------------------------------------------------------------
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] n2,
  input  logic [3:0] n1,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  // One counter serves both lit and dead intervals, so size it for the longer.
  localparam int             CNT_MAX   = max_int(REFRESH_DIV, DEAD_CYCLES);
  localparam int             CNT_W     = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LIT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit             SKIP_DEAD = (DEAD_CYCLES == 0);

  // Physical polarity masks: XOR an active-high value to get the pin value.
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_INV  = (AN_ACTIVE_LOW  != 0) ? 2'b11 : 2'b00;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [STATE_W-1:0] state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               pending_q,  pending_d;
  logic [3:0]         shadow_n2_q, shadow_n2_d;
  logic [3:0]         shadow_n1_q, shadow_n1_d;
  logic [3:0]         disp_n2_q,  disp_n2_d;
  logic [3:0]         disp_n1_q,  disp_n1_d;
  logic [6:0]         seg_q,      seg_d;
  logic [1:0]         an_q,       an_d;
  logic               frame_tick_q, frame_tick_d;

  logic               slot_last;
  logic               frame_end;
  logic [3:0]         dec_digit;
  logic [6:0]         dec_seg;

  // ---------------------------------------------------------------------------
  // Slot counter and scan FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;

    if ((state_q == ST_TENS) || (state_q == ST_ONES)) begin
      slot_last = (cnt_q == LIT_LAST);
    end else begin
      slot_last = (cnt_q == DEAD_LAST);
    end

    // Counter is cleared on every state change, so it never needs to wrap
    // past the current interval's length.
    if (slot_last) begin
      cnt_d = '0;
      unique case (state_q)
        ST_DEAD_T: state_d = ST_TENS;
        ST_TENS:   state_d = SKIP_DEAD ? ST_ONES : ST_DEAD_O;
        ST_DEAD_O: state_d = ST_ONES;
        default:   state_d = SKIP_DEAD ? ST_TENS : ST_DEAD_T;
      endcase
    end
  end

  // The frame ends on the last clock of the ones slot.
  assign frame_end = (state_q == ST_ONES) && slot_last;

  // ---------------------------------------------------------------------------
  // Capture / commit
  //   Shadow holds the latest load; display is only updated at frame_end.
  //   A load on the frame_end edge itself goes straight to the display so it
  //   is not delayed a whole extra frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_n2_d = shadow_n2_q;
    shadow_n1_d = shadow_n1_q;
    pending_d   = pending_q;
    disp_n2_d   = disp_n2_q;
    disp_n1_d   = disp_n1_q;

    if (load) begin
      shadow_n2_d = n2;
      shadow_n1_d = n1;
    end

    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_n2_d = n2;
        disp_n1_d = n1;
      end else if (pending_q) begin
        disp_n2_d = shadow_n2_q;
        disp_n1_d = shadow_n1_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: decoded from the current state, registered one clock later.
  // ---------------------------------------------------------------------------
  assign dec_digit = (state_q == ST_TENS) ? disp_n2_q : disp_n1_q;

  seven_seg_decoder u_decoder (
    .digit (dec_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    logic [6:0] seg_ah;
    logic [1:0] an_ah;

    seg_ah = SEG_OFF;
    an_ah  = 2'b00;

    unique case (state_q)
      ST_TENS: begin
        // Leading-zero blanking looks at blank_lz live, not at load time.
        if (!(blank_lz && (disp_n2_q == 4'd0))) begin
          seg_ah = dec_seg;
          an_ah  = 2'b10;
        end
      end
      ST_ONES: begin
        seg_ah = dec_seg;
        an_ah  = 2'b01;
      end
      default: begin
        seg_ah = SEG_OFF;
        an_ah  = 2'b00;
      end
    endcase

    seg_d        = seg_ah ^ SEG_INV;
    an_d         = an_ah  ^ AN_INV;
    frame_tick_d = frame_end;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DEAD_T;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      shadow_n2_q  <= 4'd0;
      shadow_n1_q  <= 4'd0;
      disp_n2_q    <= 4'd0;
      disp_n1_q    <= 4'd0;
      seg_q        <= SEG_OFF ^ SEG_INV;
      an_q         <= AN_INV;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      shadow_n2_q  <= shadow_n2_d;
      shadow_n1_q  <= shadow_n1_d;
      disp_n2_q    <= disp_n2_d;
      disp_n1_q    <= disp_n1_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule : bcd_display_scanner

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
//   Directed bench for bcd_display_scanner with REFRESH_DIV=4, DEAD_CYCLES=1,
//   both polarities active-low, giving a 10-clock frame. Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
//
//   Frame timing after a frame_tick sample (or after reset release), sample i
//   taken at the i-th following falling edge:
//     i=1       dead (an=11, seg=7F)
//     i=2..5    tens slot
//     i=6       dead
//     i=7..10   ones slot, frame_tick=1 at i=10 only
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

  // Expected active-low segment patterns, {g,f,e,d,c,b,a}.
  localparam logic [6:0] P_OFF  = 7'b1111111;
  localparam logic [6:0] P_0    = 7'b1000000;
  localparam logic [6:0] P_1    = 7'b1111001;
  localparam logic [6:0] P_3    = 7'b0110000;
  localparam logic [6:0] P_4    = 7'b0011001;
  localparam logic [6:0] P_5    = 7'b0010010;
  localparam logic [6:0] P_7    = 7'b1111000;
  localparam logic [6:0] P_9    = 7'b0010000;
  localparam logic [6:0] P_DASH = 7'b0111111;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_ONES = 2'b10;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] n2;
  logic [3:0] n1;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;

  bcd_display_scanner #(
    .REFRESH_DIV    (4),
    .DEAD_CYCLES    (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .n2         (n2),
    .n1         (n1),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk one 10-clock frame, checking seg/an/frame_tick on every sample.
  // If ld_idx matches a sample index, a one-cycle load of ln2/ln1 is driven
  // right after that sample (captured on the following rising edge).
  task automatic capture_frame(input logic [6:0] t_seg, input logic [1:0] t_an,
                               input logic [6:0] o_seg, input int ld_idx,
                               input logic [3:0] ln2, input logic [3:0] ln1);
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    frame_no++;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 5) begin
        exp_seg = t_seg;
        exp_an  = t_an;
      end else if (i >= 7) begin
        exp_seg = o_seg;
        exp_an  = AN_ONES;
      end else begin
        exp_seg = P_OFF;
        exp_an  = AN_OFF;
      end
      check($sformatf("f%0d_i%0d_seg", frame_no, i), 32'(seg), 32'(exp_seg));
      check($sformatf("f%0d_i%0d_an", frame_no, i), 32'(an), 32'(exp_an));
      check($sformatf("f%0d_i%0d_tick", frame_no, i), 32'(frame_tick), 32'(i == 10));
      if (i == ld_idx) begin
        n2   = ln2;
        n1   = ln1;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  // Drive a load strobe now (between edges); capture_frame clears it.
  task automatic start_load(input logic [3:0] ln2, input logic [3:0] ln1);
    n2   = ln2;
    n1   = ln1;
    load = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    n2       = 4'd0;
    n1       = 4'd0;
    blank_lz = 1'b0;

    // Reset state while held across clock edges.
    repeat (2) @(negedge clk);
    check("rst_seg",  32'(seg),        32'(P_OFF));
    check("rst_an",   32'(an),         32'(AN_OFF));
    check("rst_tick", 32'(frame_tick), 32'h0);

    // 1: run into the tens slot, then reset asynchronously between edges.
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_an", 32'(an), 32'(AN_TENS));
    #2 rst_n = 1'b0;
    #1;
    check("async_seg",  32'(seg),        32'(P_OFF));
    check("async_an",   32'(an),         32'(AN_OFF));
    check("async_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Display regs cleared to 0/0, no blanking.
    capture_frame(P_0, AN_TENS, P_0, 0, 4'd0, 4'd0);

    // 2: load 1/5; the current frame keeps 0/0, the next shows 1/5.
    start_load(4'd1, 4'd5);
    capture_frame(P_0, AN_TENS, P_0, 0, 4'd0, 4'd0);
    capture_frame(P_1, AN_TENS, P_5, 0, 4'd0, 4'd0);

    // 3: load 0/7 with blank_lz; tens goes dark once committed.
    blank_lz = 1'b1;
    start_load(4'd0, 4'd7);
    capture_frame(P_1, AN_TENS, P_5, 0, 4'd0, 4'd0);
    capture_frame(P_OFF, AN_OFF, P_7, 0, 4'd0, 4'd0);
    blank_lz = 1'b0;
    capture_frame(P_0, AN_TENS, P_7, 0, 4'd0, 4'd0);

    // 4: invalid codes render as a dash.
    start_load(4'hB, 4'hF);
    capture_frame(P_0, AN_TENS, P_7, 0, 4'd0, 4'd0);
    capture_frame(P_DASH, AN_TENS, P_DASH, 0, 4'd0, 4'd0);

    // 5: 1/2 then 3/4 within one frame; only 3/4 is ever shown.
    start_load(4'd1, 4'd2);
    capture_frame(P_DASH, AN_TENS, P_DASH, 4, 4'd3, 4'd4);
    // 6: load 9/9 on the frame_tick edge (driven after sample 9).
    capture_frame(P_3, AN_TENS, P_4, 9, 4'd9, 4'd9);
    capture_frame(P_9, AN_TENS, P_9, 0, 4'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bcd_display_scanner
